gpio_bank_controller: RTL and testbench

Register front-end and interrupt manager for a bank of GPIO_NUMBER single-bit gpio pin instances. It decodes CPU register accesses into per-pin write/read strobes, gathers pin read data, and generates the shared debounce tick. It latches pin interrupts into a pending register and reports the lowest pending pin index as one bank interrupt to the system interrupt controller.

---
 rtl/gpio_bank_pkg.sv | 29 ++
 rtl/gpio_bank_controller_tick_prescaler.sv | 46 ++++
 rtl/gpio_bank_controller.sv | 173 +++++++++++++++++
 tb/tb_gpio_bank_controller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg
// Shared definitions for the GPIO bank controller: the CPU register map,
// the CPU data-bus width and the layout of the INT_ID register.
package gpio_bank_pkg;

    localparam int BANK_DATA_WIDTH = 32;

    // CPU register addresses; 6 and 7 are unmapped and flagged as errors.
    typedef enum logic [2:0] {
        REG_VALUE      = 3'd0,
        REG_DIRECTION  = 3'd1,
        REG_INT_ENABLE = 3'd2,
        REG_INT_LEVEL  = 3'd3,
        REG_PENDING    = 3'd4,
        REG_INT_ID     = 3'd5
    } reg_addr_e;

    // INT_ID content: valid sits in bit 31, index in bits 4:0.
    typedef struct packed {
        logic       valid;
        logic [4:0] index;
    } int_id_t;

    // Place an INT_ID record into its 32-bit register image.
    function automatic logic [BANK_DATA_WIDTH-1:0] int_id_word(input int_id_t id);
        return {id.valid, 26'd0, id.index};
    endfunction

endpackage

// File: rtl/gpio_bank_controller_tick_prescaler.sv
// tick_prescaler
// Free-running counter 0..TICK_CYCLES-1. tick_o is a registered one-cycle
// pulse raised on the clock edge at which the counter wraps to 0, so the
// tick repeats every TICK_CYCLES cycles.
// Ports:
//   clk_i   - system clock
//   rst_n_i - asynchronous active-low reset
//   tick_o  - registered one-cycle debounce tick
module tick_prescaler #(
    parameter int TICK_CYCLES = 64516
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic tick_o
);
    localparam int CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;

    // Next count with wrap, tick raised alongside the wrap.
    always_comb begin
        if (count_q == LAST) begin
            count_d = '0;
            tick_d  = 1'b1;
        end else begin
            count_d = count_q + CNT_W'(1);
            tick_d  = 1'b0;
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/gpio_bank_controller.sv
// gpio_bank_controller
// CPU register front-end and interrupt manager for a bank of GPIO pins.
// Ports:
//   clk_i, rst_n_i                 - clock, asynchronous active-low reset
//   write_i/write_address_i/write_data_i, write_error_o - CPU write side
//   read_i/read_address_i, read_data_o/read_valid_o/read_error_o - CPU read side
//   interrupt_o                    - bank interrupt (any pending bit)
//   pin_write_o/pin_write_address_o/pin_write_data_o - pipelined pin writes
//   pin_read_address_o/pin_read_data_i - combinational pin read path
//   pin_interrupt_i                - per-pin interrupt levels
//   debounce_o                     - shared debounce tick
module gpio_bank_controller
    import gpio_bank_pkg::*;
#(
    parameter int GPIO_NUMBER = 8,
    parameter int TICK_CYCLES = 64516
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       write_i,
    input  logic [2:0]                 write_address_i,
    input  logic [BANK_DATA_WIDTH-1:0] write_data_i,
    output logic                       write_error_o,
    input  logic                       read_i,
    input  logic [2:0]                 read_address_i,
    output logic [BANK_DATA_WIDTH-1:0] read_data_o,
    output logic                       read_valid_o,
    output logic                       read_error_o,
    output logic                       interrupt_o,
    output logic [GPIO_NUMBER-1:0]     pin_write_o,
    output logic [1:0]                 pin_write_address_o,
    output logic [GPIO_NUMBER-1:0]     pin_write_data_o,
    output logic [1:0]                 pin_read_address_o,
    input  logic [GPIO_NUMBER-1:0]     pin_read_data_i,
    input  logic [GPIO_NUMBER-1:0]     pin_interrupt_i,
    output logic                       debounce_o
);

    // Fixed priority: lowest set index wins (scan high to low, last hit kept).
    function automatic int_id_t lowest_pending(input logic [GPIO_NUMBER-1:0] pend);
        int_id_t id;
        id.valid = 1'b0;
        id.index = 5'd0;
        for (int i = GPIO_NUMBER - 1; i >= 0; i--) begin
            id.index = pend[i] ? 5'(i) : id.index;
            id.valid = id.valid | pend[i];
        end
        return id;
    endfunction

    logic [GPIO_NUMBER-1:0]     pin_write_q, pin_write_d;
    logic [1:0]                 pin_write_address_q, pin_write_address_d;
    logic [GPIO_NUMBER-1:0]     pin_write_data_q, pin_write_data_d;
    logic                       write_error_q, write_error_d;
    logic [BANK_DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                       read_valid_q, read_error_q, read_error_d;
    logic [GPIO_NUMBER-1:0]     pending_q, pending_d;
    logic [GPIO_NUMBER-1:0]     int_prev_q;
    logic                       interrupt_q;
    logic [GPIO_NUMBER-1:0]     rise_s, clear_s;
    logic [BANK_DATA_WIDTH-1:0] int_id_word_s;
    logic                       unused_write_bits_s;

    // Upper write-data bits beyond the pin count are intentionally dropped.
    assign unused_write_bits_s = ^write_data_i;

    assign int_id_word_s = int_id_word(lowest_pending(pending_q));

    // Write decode: pin registers 0-3 get a strobe, 5-7 raise an error.
    always_comb begin
        pin_write_address_d = pin_write_address_q;
        pin_write_data_d    = pin_write_data_q;
        pin_write_d         = '0;
        write_error_d       = 1'b0;
        if (write_i) begin
            case (write_address_i)
                REG_VALUE, REG_DIRECTION, REG_INT_ENABLE, REG_INT_LEVEL: begin
                    pin_write_d         = {GPIO_NUMBER{1'b1}};
                    pin_write_address_d = write_address_i[1:0];
                    pin_write_data_d    = write_data_i[GPIO_NUMBER-1:0];
                end
                REG_PENDING: begin
                    pin_write_d = '0;
                end
                default: begin
                    write_error_d = 1'b1;
                end
            endcase
        end else begin
            pin_write_d = '0;
        end
    end

    // Read mux; read_data holds between reads.
    always_comb begin
        read_data_d  = read_data_q;
        read_error_d = 1'b0;
        if (read_i) begin
            case (read_address_i)
                REG_VALUE, REG_DIRECTION, REG_INT_ENABLE, REG_INT_LEVEL:
                    read_data_d = BANK_DATA_WIDTH'(pin_read_data_i);
                REG_PENDING:
                    read_data_d = BANK_DATA_WIDTH'(pending_q);
                REG_INT_ID:
                    read_data_d = int_id_word_s;
                default: begin
                    read_data_d  = '0;
                    read_error_d = 1'b1;
                end
            endcase
        end else begin
            read_data_d = read_data_q;
        end
    end

    // Pending update: new rising edges are OR-ed after the W1C so set wins.
    always_comb begin
        rise_s = pin_interrupt_i & ~int_prev_q;
        if (write_i && (write_address_i == REG_PENDING)) begin
            clear_s = write_data_i[GPIO_NUMBER-1:0];
        end else begin
            clear_s = '0;
        end
        pending_d = (pending_q & ~clear_s) | rise_s;
    end

    // Register stage for all CPU-facing and pin-facing outputs and state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pin_write_q         <= '0;
            pin_write_address_q <= 2'd0;
            pin_write_data_q    <= '0;
            write_error_q       <= 1'b0;
            read_data_q         <= '0;
            read_valid_q        <= 1'b0;
            read_error_q        <= 1'b0;
            pending_q           <= '0;
            int_prev_q          <= '0;
            interrupt_q         <= 1'b0;
        end else begin
            pin_write_q         <= pin_write_d;
            pin_write_address_q <= pin_write_address_d;
            pin_write_data_q    <= pin_write_data_d;
            write_error_q       <= write_error_d;
            read_data_q         <= read_data_d;
            read_valid_q        <= read_i;
            read_error_q        <= read_error_d;
            pending_q           <= pending_d;
            int_prev_q          <= pin_interrupt_i;
            // Taken from pending_d so it tracks the pending register exactly.
            interrupt_q         <= |pending_d;
        end
    end

    tick_prescaler #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_prescaler (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .tick_o  (debounce_o)
    );

    assign pin_read_address_o  = read_address_i[1:0];
    assign pin_write_o         = pin_write_q;
    assign pin_write_address_o = pin_write_address_q;
    assign pin_write_data_o    = pin_write_data_q;
    assign write_error_o       = write_error_q;
    assign read_data_o         = read_data_q;
    assign read_valid_o        = read_valid_q;
    assign read_error_o        = read_error_q;
    assign interrupt_o         = interrupt_q;

endmodule

// File: tb/tb_gpio_bank_controller.sv
// Testbench for gpio_bank_controller (GPIO_NUMBER=8, TICK_CYCLES=4).
module tb_gpio_bank_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic        rd;
    logic [2:0]  raddr;
    logic [7:0]  prd;
    logic [7:0]  pint;

    logic        write_error;
    logic [31:0] read_data;
    logic        read_valid, read_error, interrupt, debounce;
    logic [7:0]  pin_write, pin_write_data;
    logic [1:0]  pin_write_address, pin_read_address;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0]  m_pend;
    logic [7:0]  m_prev;
    logic [31:0] m_rdata;
    int          m_edges;

    // Last per-cycle expectations (used by the table rows too).
    logic        x_intr;

    always #5 clk = ~clk;

    gpio_bank_controller #(
        .GPIO_NUMBER (8),
        .TICK_CYCLES (4)
    ) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .write_i             (wr),
        .write_address_i     (waddr),
        .write_data_i        (wdata),
        .write_error_o       (write_error),
        .read_i              (rd),
        .read_address_i      (raddr),
        .read_data_o         (read_data),
        .read_valid_o        (read_valid),
        .read_error_o        (read_error),
        .interrupt_o         (interrupt),
        .pin_write_o         (pin_write),
        .pin_write_address_o (pin_write_address),
        .pin_write_data_o    (pin_write_data),
        .pin_read_address_o  (pin_read_address),
        .pin_read_data_i     (prd),
        .pin_interrupt_i     (pint),
        .debounce_o          (debounce)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, want, $time);
        end
    endtask

    // Lowest pending pin index, as the INT_ID register reports it.
    function automatic logic [31:0] int_id_of(input logic [7:0] p);
        for (int k = 0; k < 8; k++) begin
            if (p[k]) return 32'h8000_0000 | 32'(k);
        end
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_pend  = 8'd0;
        m_prev  = 8'd0;
        m_rdata = 32'd0;
        m_edges = 0;
    endtask

    task automatic idle();
        wr = 1'b0; waddr = 3'd0; wdata = 32'd0;
        rd = 1'b0; raddr = 3'd0;
    endtask

    task automatic all_zero_check(input string nm);
        chk({nm, "_werr"}, 32'(write_error), 32'd0);
        chk({nm, "_rdata"}, read_data, 32'd0);
        chk({nm, "_rvalid"}, 32'(read_valid), 32'd0);
        chk({nm, "_rerr"}, 32'(read_error), 32'd0);
        chk({nm, "_intr"}, 32'(interrupt), 32'd0);
        chk({nm, "_pw"}, 32'(pin_write), 32'd0);
        chk({nm, "_pwa"}, 32'(pin_write_address), 32'd0);
        chk({nm, "_pwd"}, 32'(pin_write_data), 32'd0);
        chk({nm, "_deb"}, 32'(debounce), 32'd0);
    endtask

    // One clock cycle with current inputs; model predicts, then compare.
    task automatic cycle();
        logic [7:0] e_pw;
        logic       e_werr, e_rv, e_re, e_deb;
        logic [7:0] new_pend;
        #1;
        chk("pin_read_address", 32'(pin_read_address), 32'(raddr[1:0]));
        e_pw   = (wr && waddr < 3'd4) ? 8'hFF : 8'h00;
        e_werr = wr && (waddr >= 3'd5);
        e_rv   = rd;
        e_re   = rd && (raddr >= 3'd6);
        if (rd) begin
            if (raddr < 3'd4)       m_rdata = {24'd0, prd};
            else if (raddr == 3'd4) m_rdata = {24'd0, m_pend};
            else if (raddr == 3'd5) m_rdata = int_id_of(m_pend);
            else                    m_rdata = 32'd0;
        end
        for (int k = 0; k < 8; k++) begin
            if (pint[k] && !m_prev[k])                new_pend[k] = 1'b1;
            else if (wr && waddr == 3'd4 && wdata[k]) new_pend[k] = 1'b0;
            else                                      new_pend[k] = m_pend[k];
        end
        m_pend  = new_pend;
        m_prev  = pint;
        m_edges = m_edges + 1;
        e_deb   = (m_edges % 4) == 0;
        x_intr  = (m_pend != 8'd0);
        @(posedge clk);
        #1;
        chk("pin_write", 32'(pin_write), 32'(e_pw));
        if (e_pw != 8'd0) begin
            chk("pin_write_address", 32'(pin_write_address), 32'(waddr[1:0]));
            chk("pin_write_data", 32'(pin_write_data), 32'(wdata[7:0]));
        end
        chk("write_error", 32'(write_error), 32'(e_werr));
        chk("read_valid", 32'(read_valid), 32'(e_rv));
        chk("read_error", 32'(read_error), 32'(e_re));
        chk("read_data", read_data, m_rdata);
        chk("interrupt", 32'(interrupt), 32'(x_intr));
        chk("debounce", 32'(debounce), 32'(e_deb));
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic        rd;
        logic [2:0]  ra;
        logic [7:0]  prd;
        logic [7:0]  pint;
        logic [7:0]  e_pw;
        logic        e_werr;
        logic        e_rv;
        logic        e_re;
        logic [31:0] e_rd;
        logic        e_intr;
    } vec_t;

    vec_t vecs[19];

    initial begin
        //            wr  wa    wd            rd  ra    prd    pint   e_pw   werr  rv    re    e_rd          intr
        vecs[0]  = '{1'b1, 3'd1, 32'h0000_000F, 1'b0, 3'd0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0};
        vecs[1]  = '{1'b0, 3'd0, 32'h0,         1'b0, 3'd0, 8'h00, 8'h24, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,          1'b1};
        vecs[2]  = '{1'b0, 3'd0, 32'h0,         1'b1, 3'd4, 8'h00, 8'h24, 8'h00, 1'b0, 1'b1, 1'b0, 32'h24,         1'b1};
        vecs[3]  = '{1'b0, 3'd0, 32'h0,         1'b1, 3'd5, 8'h00, 8'h24, 8'h00, 1'b0, 1'b1, 1'b0, 32'h8000_0002,  1'b1};
        vecs[4]  = '{1'b1, 3'd4, 32'h0000_0004, 1'b0, 3'd0, 8'h00, 8'h24, 8'h00, 1'b0, 1'b0, 1'b0, 32'h8000_0002,  1'b1};
        vecs[5]  = '{1'b0, 3'd0, 32'h0,         1'b1, 3'd5, 8'h00, 8'h24, 8'h00, 1'b0, 1'b1, 1'b0, 32'h8000_0005,  1'b1};
        vecs[6]  = '{1'b1, 3'd4, 32'h0000_0020, 1'b0, 3'd0, 8'h00, 8'h24, 8'h00, 1'b0, 1'b0, 1'b0, 32'h8000_0005,  1'b0};
        vecs[7]  = '{1'b0, 3'd0, 32'h0,         1'b1, 3'd5, 8'h00, 8'h24, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0};
        vecs[8]  = '{1'b0, 3'd0, 32'h0,         1'b1, 3'd4, 8'h00, 8'h24, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,          1'b0};
        vecs[9]  = '{1'b0, 3'd0, 32'h0,         1'b1, 3'd4, 8'h00, 8'h2C, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,          1'b1};
        vecs[10] = '{1'b0, 3'd0, 32'h0,         1'b1, 3'd4, 8'h00, 8'h24, 8'h00, 1'b0, 1'b1, 1'b0, 32'h08,         1'b1};
        vecs[11] = '{1'b1, 3'd4, 32'h0000_0008, 1'b0, 3'd0, 8'h00, 8'h2C, 8'h00, 1'b0, 1'b0, 1'b0, 32'h08,         1'b1};
        vecs[12] = '{1'b0, 3'd0, 32'h0,         1'b1, 3'd4, 8'h00, 8'h2C, 8'h00, 1'b0, 1'b1, 1'b0, 32'h08,         1'b1};
        vecs[13] = '{1'b0, 3'd0, 32'h0,         1'b1, 3'd7, 8'h00, 8'h2C, 8'h00, 1'b0, 1'b1, 1'b1, 32'h0,          1'b1};
        vecs[14] = '{1'b1, 3'd6, 32'hFFFF_FFFF, 1'b0, 3'd0, 8'h00, 8'h2C, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0,          1'b1};
        vecs[15] = '{1'b1, 3'd5, 32'hFFFF_FFFF, 1'b1, 3'd0, 8'hA5, 8'h2C, 8'h00, 1'b1, 1'b1, 1'b0, 32'hA5,         1'b1};
        vecs[16] = '{1'b0, 3'd0, 32'h0,         1'b0, 3'd0, 8'h00, 8'h2C, 8'h00, 1'b0, 1'b0, 1'b0, 32'hA5,         1'b1};
        vecs[17] = '{1'b1, 3'd3, 32'h1234_56C3, 1'b0, 3'd0, 8'h00, 8'h2C, 8'hFF, 1'b0, 1'b0, 1'b0, 32'hA5,         1'b1};
        vecs[18] = '{1'b0, 3'd0, 32'h0,         1'b1, 3'd4, 8'h00, 8'h2C, 8'h00, 1'b0, 1'b1, 1'b0, 32'h08,         1'b1};

        // Reset state.
        rst_n = 1'b0;
        idle();
        prd  = 8'h00;
        pint = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        all_zero_check("reset");
        rst_n = 1'b1;

        // Debounce tick with TICK_CYCLES=4: edges 4, 8, 12 after release.
        for (int n = 1; n <= 12; n++) begin
            cycle();
            chk("debounce_seq", 32'(debounce), 32'((n % 4) == 0));
        end

        // Directed vector table.
        for (int i = 0; i < 19; i++) begin
            wr = vecs[i].wr; waddr = vecs[i].wa; wdata = vecs[i].wd;
            rd = vecs[i].rd; raddr = vecs[i].ra; prd = vecs[i].prd;
            pint = vecs[i].pint;
            cycle();
            chk($sformatf("vec%0d_pw", i), 32'(pin_write), 32'(vecs[i].e_pw));
            if (vecs[i].e_pw != 8'd0) begin
                chk($sformatf("vec%0d_pwa", i), 32'(pin_write_address), 32'(vecs[i].wa[1:0]));
                chk($sformatf("vec%0d_pwd", i), 32'(pin_write_data), 32'(vecs[i].wd[7:0]));
            end
            chk($sformatf("vec%0d_werr", i), 32'(write_error), 32'(vecs[i].e_werr));
            chk($sformatf("vec%0d_rvalid", i), 32'(read_valid), 32'(vecs[i].e_rv));
            chk($sformatf("vec%0d_rerr", i), 32'(read_error), 32'(vecs[i].e_re));
            chk($sformatf("vec%0d_rdata", i), read_data, vecs[i].e_rd);
            chk($sformatf("vec%0d_intr", i), 32'(interrupt), 32'(vecs[i].e_intr));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            wr    = ($urandom_range(0, 9) < 4);
            waddr = 3'($urandom_range(0, 7));
            wdata = $urandom;
            rd    = ($urandom_range(0, 9) < 5);
            raddr = 3'($urandom_range(0, 7));
            prd   = 8'($urandom);
            pint  = pint ^ 8'($urandom & $urandom & $urandom);
            cycle();
        end

        // Reset asserted with a write and read in flight: both are dropped.
        wr = 1'b1; waddr = 3'd0; wdata = 32'hFF;
        rd = 1'b1; raddr = 3'd4; pint = 8'h00;
        #3;
        rst_n = 1'b0;
        #1;
        all_zero_check("midreset");
        @(posedge clk);
        idle();
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
